// File: rtl/regfile_dumper_pkg.sv
// rtl/regfile_dumper_pkg.sv - shared widths and FSM state encoding for the register-file dumper
package regfile_dumper_pkg;

  localparam int REGWIDTH_DEF = 32;
  localparam int ADDSIZE_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dumpState_t;

endpackage

// File: rtl/regfile_dumper.sv
// rtl/regfile_dumper.sv - walks one register-file read port and streams each value out
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int REGWIDTH  = REGWIDTH_DEF,
  parameter int ADDSIZE   = ADDSIZE_DEF,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  output logic [ADDSIZE-1:0]  RA,
  input  logic [REGWIDTH-1:0] BusA,
  output logic [REGWIDTH-1:0] Data,
  output logic [ADDSIZE-1:0]  Index,
  output logic                Valid,
  input  logic                Ready,
  output logic                Busy,
  output logic                Done
);

  localparam logic [ADDSIZE-1:0] FirstAddr = ADDSIZE'(FIRST_REG);
  localparam logic [ADDSIZE-1:0] LastAddr  = ADDSIZE'(LAST_REG);

  dumpState_t state;

  // Dump FSM; RA doubles as the walk counter and stops at LAST_REG so it never wraps.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      RA    <= FirstAddr;
      Data  <= '0;
      Index <= '0;
      Valid <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            RA    <= FirstAddr;
            state <= FETCH;
          end
        end
        FETCH: begin
          // BusA is combinational on RA, so the value seen here includes any falling-edge write
          Data  <= BusA;
          Index <= RA;
          Valid <= 1'b1;
          state <= SEND;
        end
        SEND: begin
          if (Ready) begin
            Valid <= 1'b0;
            if (RA == LastAddr) begin
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              RA    <= RA + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Busy is a pure decode of the state register
  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_regfile_dumper.sv
// tb/tb_regfile_dumper.sv - self-checking bench for regfile_dumper with a behavioural register file
module tb_regfile_dumper;

  typedef struct {
    bit    randReady;
    bit    hazard;
    bit    startSpam;
    int    expDoneCycle;
    string name;
  } scenario_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Ready = 1'b1;
  logic        Start2 = 1'b0;
  logic        Ready2 = 1'b1;
  logic [4:0]  RA, RA2, Index, Index2;
  logic [31:0] BusA, BusA2, Data, Data2;
  logic        Valid, Valid2, Busy, Busy2, Done, Done2;

  logic [31:0] mem [32];
  int errors = 0;
  int checks = 0;
  scenario_t scen [4];

  always #5 Clk = ~Clk;

  // register file read ports: r0 is hardwired to zero
  assign BusA  = (RA  == 5'd0) ? 32'h0 : mem[RA];
  assign BusA2 = (RA2 == 5'd0) ? 32'h0 : mem[RA2];

  regfile_dumper #(.REGWIDTH(32), .ADDSIZE(5), .FIRST_REG(0), .LAST_REG(31)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RA(RA), .BusA(BusA), .Data(Data),
    .Index(Index), .Valid(Valid), .Ready(Ready), .Busy(Busy), .Done(Done)
  );

  regfile_dumper #(.REGWIDTH(32), .ADDSIZE(5), .FIRST_REG(7), .LAST_REG(7)) dutOne (
    .Clk(Clk), .Reset(Reset), .Start(Start2), .RA(RA2), .BusA(BusA2), .Data(Data2),
    .Index(Index2), .Valid(Valid2), .Ready(Ready2), .Busy(Busy2), .Done(Done2)
  );

  function automatic logic [31:0] preload(int i);
    logic [7:0] b;
    b = 8'h10 + 8'(i);
    return (i == 0) ? 32'h0 : {4{b}};
  endfunction

  task automatic loadMem();
    for (int i = 0; i < 32; i++) mem[i] = preload(i);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full 0..31 dump, collected at falling edges and compared with a snapshot model
  task automatic runDump(input scenario_t s);
    logic [31:0] expWord [32];
    logic [31:0] gotData [$];
    logic [4:0]  gotIdx [$];
    logic [31:0] prevData;
    logic [4:0]  prevIdx;
    bit stalled, r3Pending;
    int doneCount, doneCycle, cyc;
    stalled = 0; r3Pending = 0; doneCount = 0; doneCycle = -1;
    prevData = '0; prevIdx = '0;
    loadMem();
    for (int i = 0; i < 32; i++) expWord[i] = preload(i);
    if (s.hazard) expWord[20] = 32'hCAFEF00D;

    @(negedge Clk);
    Start = 1'b1;
    Ready = s.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge Clk);
      cyc++;
      Start = 1'b0;
      if (s.startSpam && Busy && $urandom_range(0, 2) == 0) Start = 1'b1;
      if (cyc == 1) begin
        check({s.name, " busy after start"}, 32'(Busy), 32'd1);
        check({s.name, " no valid in fetch"}, 32'(Valid), 32'd0);
      end
      if (cyc == 2) check({s.name, " valid two cycles after start"}, 32'(Valid), 32'd1);
      if (stalled) begin
        check({s.name, " stall valid"}, 32'(Valid), 32'd1);
        check({s.name, " stall data"}, Data, prevData);
        check({s.name, " stall index"}, 32'(Index), 32'(prevIdx));
      end
      if (Done) begin
        doneCount++;
        doneCycle = cyc;
      end
      if (s.hazard && r3Pending) begin
        mem[3] = 32'h0;
        r3Pending = 0;
      end
      if (s.hazard && Busy && !Valid && RA == 5'd20) mem[20] = 32'hCAFEF00D;
      Ready = s.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (Valid && Ready) begin
        gotData.push_back(Data);
        gotIdx.push_back(Index);
        if (Index == 5'd3) r3Pending = 1;
        stalled = 0;
      end else if (Valid) begin
        stalled = 1;
        prevData = Data;
        prevIdx = Index;
      end else begin
        stalled = 0;
      end
      if (doneCount > 0 && cyc > doneCycle + 2) break;
    end
    Start = 1'b0;
    Ready = 1'b1;

    check({s.name, " word count"}, 32'(gotData.size()), 32'd32);
    for (int i = 0; i < 32 && i < gotData.size(); i++) begin
      check($sformatf("%s index %0d", s.name, i), 32'(gotIdx[i]), 32'(i));
      check($sformatf("%s data %0d", s.name, i), gotData[i], expWord[i]);
    end
    check({s.name, " done pulses"}, 32'(doneCount), 32'd1);
    // Done lands in the 66th cycle counting the Start cycle as the first
    if (s.expDoneCycle >= 0) check({s.name, " done latency"}, 32'(doneCycle), 32'(s.expDoneCycle));
    check({s.name, " idle after done"}, 32'(Busy), 32'd0);
    check({s.name, " no valid after done"}, 32'(Valid), 32'd0);
  endtask

  // Stall at word 12, then reset asynchronously in the middle of a cycle
  task automatic resetMidDump();
    bit found;
    found = 0;
    loadMem();
    @(negedge Clk);
    Start = 1'b1;
    Ready = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Valid && Index == 5'd12) begin
        Ready = 1'b0;
        found = 1;
      end
    end
    check("reached index 12", 32'(found), 32'd1);
    repeat (3) @(negedge Clk);
    check("stalled valid at 12", 32'(Valid), 32'd1);
    check("stalled index 12", 32'(Index), 32'd12);
    check("stalled data 12", Data, preload(12));
    #2 Reset = 1'b1;
    #1;
    check("reset valid", 32'(Valid), 32'd0);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset data", Data, 32'd0);
    check("reset index", 32'(Index), 32'd0);
    check("reset ra", 32'(RA), 32'd0);
    Ready = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check("no done during reset", 32'(Done), 32'd0);
    end
    Reset = 1'b0;
  endtask

  // FIRST_REG == LAST_REG == 7 produces exactly one word then Done
  task automatic singleWord();
    mem[7] = 32'hDEADBEEF;
    @(negedge Clk);
    Start2 = 1'b1;
    Ready2 = 1'b1;
    @(negedge Clk);
    Start2 = 1'b0;
    check("single busy", 32'(Busy2), 32'd1);
    check("single ra", 32'(RA2), 32'd7);
    @(negedge Clk);
    check("single valid", 32'(Valid2), 32'd1);
    check("single index", 32'(Index2), 32'd7);
    check("single data", Data2, 32'hDEADBEEF);
    @(negedge Clk);
    check("single done", 32'(Done2), 32'd1);
    check("single valid dropped", 32'(Valid2), 32'd0);
    check("single busy in done", 32'(Busy2), 32'd1);
    @(negedge Clk);
    check("single done one cycle", 32'(Done2), 32'd0);
    check("single idle", 32'(Busy2), 32'd0);
    check("single no second word", 32'(Valid2), 32'd0);
  endtask

  initial begin
    scen[0] = '{1'b0, 1'b0, 1'b0, 65, "full"};
    scen[1] = '{1'b1, 1'b0, 1'b0, -1, "randready"};
    scen[2] = '{1'b0, 1'b1, 1'b0, 65, "hazard"};
    scen[3] = '{1'b1, 1'b0, 1'b1, -1, "startspam"};
    loadMem();

    #1 Reset = 1'b1;
    #1;
    check("por valid", 32'(Valid), 32'd0);
    check("por busy", 32'(Busy), 32'd0);
    check("por done", 32'(Done), 32'd0);
    check("por data", Data, 32'd0);
    check("por index", 32'(Index), 32'd0);
    check("por ra", 32'(RA), 32'd0);
    check("por ra second instance", 32'(RA2), 32'd7);
    @(negedge Clk);
    Reset = 1'b0;

    for (int k = 0; k < 4; k++) runDump(scen[k]);
    resetMidDump();
    runDump(scen[0]);
    singleWord();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
